// File: rtl/jk_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jk_count_ctrl
//  Description : Sequencing controller for an external W-bit JK flip-flop bank.
//                Drives per-bit j/k so the bank loads, counts up/down modulo a
//                programmable modulus, pauses, or stops after one wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_count_ctrl #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    input  logic         up,
    input  logic [W-1:0] modulus,
    input  logic         oneshot,
    input  logic         step_en,
    input  logic [W-1:0] q_in,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    output logic         busy,
    output logic         tc,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [W-1:0] c_ZERO = '0;
    localparam logic [W-1:0] c_ONES = '1;
    localparam logic [W-1:0] c_ONE  = W'(1);

    state_t       r_state_q;
    state_t       w_state_d;
    logic         r_done_q;
    logic         w_done_d;
    logic         r_pend_q;   // start seen together with the accepted load
    logic         w_pend_d;

    logic         w_mod_zero;
    logic [W-1:0] w_last;
    logic         w_above;
    logic [W-1:0] w_up_next;
    logic [W-1:0] w_dn_next;
    logic [W-1:0] w_step_next;
    logic [W-1:0] w_term;
    logic         w_at_term;
    logic [W-1:0] w_target;
    logic         w_tc;
    logic         w_busy;

    // Modulus 0 stands for 2^W, whose last value is all ones.
    assign w_mod_zero  = (modulus == c_ZERO);
    assign w_last      = w_mod_zero ? c_ONES : (modulus - c_ONE);
    assign w_above     = !w_mod_zero && (q_in >= modulus);

    assign w_up_next   = (q_in >= w_last) ? c_ZERO : (q_in + c_ONE);
    assign w_dn_next   = ((q_in == c_ZERO) || w_above) ? w_last : (q_in - c_ONE);
    assign w_step_next = up ? w_up_next : w_dn_next;

    assign w_term      = up ? w_last : c_ZERO;
    assign w_at_term   = (q_in == w_term);

    always_comb begin
        w_state_d = r_state_q;
        w_done_d  = r_done_q;
        w_pend_d  = r_pend_q;
        w_target  = q_in;
        w_tc      = 1'b0;
        w_busy    = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (load_en) begin
                    w_state_d = S_LOAD;
                    w_pend_d  = start;
                end else if (start) begin
                    w_state_d = S_RUN;
                end
            end
            S_LOAD: begin
                w_busy    = 1'b1;
                w_target  = load_val;
                w_state_d = r_pend_q ? S_RUN : S_IDLE;
                w_pend_d  = 1'b0;
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_tc   = step_en && w_at_term;
                if (stop) begin
                    w_state_d = S_IDLE;
                end else if (step_en) begin
                    w_target = w_step_next;
                    if (w_at_term && oneshot) begin
                        w_state_d = S_DONE;
                        w_done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (load_en) begin
                    w_state_d = S_LOAD;
                    w_pend_d  = start;
                    w_done_d  = 1'b0;
                end else if (start) begin
                    w_state_d = S_RUN;
                    w_done_d  = 1'b0;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_done_d  = 1'b0;
                w_pend_d  = 1'b0;
            end
        endcase
    end

    // Toggle exactly the bits that differ; everything else holds.
    assign j    = q_in ^ w_target;
    assign k    = q_in ^ w_target;
    assign tc   = w_tc;
    assign busy = w_busy;
    assign done = r_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_done_q  <= 1'b0;
            r_pend_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_done_q  <= w_done_d;
            r_pend_q  <= w_pend_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jk_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_count_ctrl
//  Description : Bench for jk_count_ctrl with a behavioural JK bank in the
//                feedback loop and a per-cycle reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_count_ctrl;

    localparam int W = 3;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         load_en = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         up = 1'b1;
    logic [W-1:0] modulus = '0;
    logic         oneshot = 1'b0;
    logic         step_en = 1'b0;
    logic [W-1:0] q_in;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         busy;
    logic         tc;
    logic         done;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    jk_count_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .load_en(load_en),
        .load_val(load_val), .up(up), .modulus(modulus), .oneshot(oneshot),
        .step_en(step_en), .q_in(q_in), .j(j), .k(k), .busy(busy), .tc(tc),
        .done(done)
    );

    // Behavioural JK flip-flop bank with synchronous reset.
    always @(posedge clk) begin
        if (rst) begin
            q_in <= '0;
        end else begin
            for (int b = 0; b < W; b++) begin
                case ({j[b], k[b]})
                    2'b01:   q_in[b] <= 1'b0;
                    2'b10:   q_in[b] <= 1'b1;
                    2'b11:   q_in[b] <= ~q_in[b];
                    default: q_in[b] <= q_in[b];
                endcase
            end
        end
    end

    // Reference model: phase, count value, done flag, pending start.
    int       mph, n_ph;
    int       mcnt, n_cnt;
    logic     mdone, n_done;
    logic     mpend, n_pend;
    logic     mvalid = 1'b0;
    int       m_mod, m_term, m_next, m_target;
    int       e_jk;
    logic     e_tc, e_busy;

    always_comb begin
        m_mod  = (modulus == 0) ? (1 << W) : int'(modulus);
        m_term = up ? m_mod - 1 : 0;
        if (up)
            m_next = (mcnt >= m_mod - 1) ? 0 : mcnt + 1;
        else
            m_next = (mcnt == 0 || mcnt >= m_mod) ? m_mod - 1 : mcnt - 1;
        m_target = mcnt;
        n_ph     = mph;
        n_done   = mdone;
        n_pend   = mpend;
        e_tc     = 1'b0;
        e_busy   = (mph == P_LOAD) || (mph == P_RUN);
        if (mph == P_IDLE || mph == P_DONE) begin
            if (load_en) begin
                n_ph   = P_LOAD;
                n_pend = start;
                n_done = 1'b0;
            end else if (start) begin
                n_ph   = P_RUN;
                n_done = 1'b0;
            end
        end else if (mph == P_LOAD) begin
            m_target = int'(load_val);
            n_ph     = mpend ? P_RUN : P_IDLE;
            n_pend   = 1'b0;
        end else begin
            e_tc = step_en && (mcnt == m_term);
            if (stop) begin
                n_ph = P_IDLE;
            end else if (step_en) begin
                m_target = m_next;
                if (mcnt == m_term && oneshot) begin
                    n_ph   = P_DONE;
                    n_done = 1'b1;
                end
            end
        end
        e_jk  = (mcnt ^ m_target) & ((1 << W) - 1);
        n_cnt = m_target;
    end

    always @(posedge clk) begin
        if (rst) begin
            mph    <= P_IDLE;
            mcnt   <= 0;
            mdone  <= 1'b0;
            mpend  <= 1'b0;
            mvalid <= 1'b1;
        end else if (mvalid) begin
            mph   <= n_ph;
            mcnt  <= n_cnt;
            mdone <= n_done;
            mpend <= n_pend;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle, then advance an edge.
    task automatic tick();
        @(negedge clk);
        if (mvalid) begin
            chk("model q_in", int'(q_in), mcnt);
            chk("model j", int'(j), e_jk);
            chk("model k", int'(k), e_jk);
            chk("model tc", int'(tc), int'(e_tc));
            chk("model busy", int'(busy), int'(e_busy));
            chk("model done", int'(done), int'(mdone));
        end
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] up_seq [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    logic [W-1:0] dn_seq [6] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
    logic [W-1:0] ql_seq [4] = '{3'd0, 3'd1, 3'd1, 3'd2};

    initial begin
        // Reset for two edges, all other inputs low.
        tick();
        tick();
        rst = 1'b0;
        chk("reset q_in", int'(q_in), 0);
        chk("reset j", int'(j), 0);
        chk("reset k", int'(k), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset tc", int'(tc), 0);
        chk("reset done", int'(done), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle hold q_in", int'(q_in), 0);
        end

        // Up-count modulo 5, free running.
        modulus = 3'd5; up = 1'b1; oneshot = 1'b0; step_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("up seq q_in", int'(q_in), int'(up_seq[i]));
            chk("up seq tc", int'(tc), (up_seq[i] == 3'd4) ? 1 : 0);
            if (up_seq[i] == 3'd3) begin
                chk("up 3->4 j", int'(j), 7);
                chk("up 3->4 k", int'(k), 7);
            end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("up stop busy", int'(busy), 0);
        chk("up stop q_in", int'(q_in), 2);

        // Load 3 with start, then count down modulo 8.
        modulus = 3'd0; up = 1'b0; load_val = 3'd3; load_en = 1'b1; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        chk("load busy", int'(busy), 1);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("down seq q_in", int'(q_in), int'(dn_seq[i]));
            chk("down seq tc", int'(tc), (dn_seq[i] == 3'd0) ? 1 : 0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // One-shot modulo 3, run twice.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modulus = 3'd3; up = 1'b1; oneshot = 1'b1; step_en = 1'b1;
        chk("oneshot pre q_in", int'(q_in), 0);
        for (int r = 0; r < 2; r++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("oneshot run done", int'(done), 0);
            chk("oneshot run busy", int'(busy), 1);
            for (int i = 0; i < 3; i++) begin
                chk("oneshot seq q_in", int'(q_in), i);
                tick();
            end
            chk("oneshot end q_in", int'(q_in), 0);
            chk("oneshot end done", int'(done), 1);
            chk("oneshot end busy", int'(busy), 0);
            tick();
            tick();
            tick();
            chk("oneshot hold q_in", int'(q_in), 0);
            chk("oneshot hold done", int'(done), 1);
        end

        // Alternating qualifier, then stop+start together at q_in = 2.
        oneshot = 1'b0; modulus = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step_en = (i % 2 == 0);
            chk("qual seq q_in", int'(q_in), int'(ql_seq[i]));
            tick();
        end
        stop = 1'b1; start = 1'b1; step_en = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("stop busy", int'(busy), 0);
        chk("stop q_in", int'(q_in), 2);
        tick();
        tick();
        chk("stop hold q_in", int'(q_in), 2);

        // Reset in the middle of a run at q_in = 5.
        start = 1'b1; step_en = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("midrun pre q_in", int'(q_in), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun q_in", int'(q_in), 0);
        chk("midrun busy", int'(busy), 0);
        chk("midrun j", int'(j), 0);
        chk("midrun k", int'(k), 0);
        chk("midrun done", int'(done), 0);
        tick();
        tick();
        chk("midrun idle q_in", int'(q_in), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
